min_max_seq: RTL and testbench



---
 rtl/min_max_seq.sv | 161 ++++++++++++++++
 tb/tb_min_max_seq.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/min_max_seq.sv
// Registered min/max LED bar display with handshaked configuration,
// internal blink generator, peak-hold and dot modes.
module min_max_seq #(
  parameter int unsigned VALSIZE   = 4,
  parameter int unsigned BLINK_DIV = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    cfg_valid_i,
  output logic                    cfg_ready_o,
  input  logic [2:0]              cfg_com_i,
  input  logic [VALSIZE-1:0]      cfg_min_i,
  input  logic [VALSIZE-1:0]      cfg_max_i,
  output logic                    cfg_err_o,
  input  logic                    val_valid_i,
  input  logic [VALSIZE-1:0]      val_i,
  output logic [(2**VALSIZE)-1:0] leds_o
);

  localparam int unsigned NLED = 2 ** VALSIZE;
  localparam int unsigned CW   = $clog2(BLINK_DIV);
  localparam int unsigned IW   = VALSIZE + 1;

  localparam logic [2:0] MODE_NORMAL = 3'b000;
  localparam logic [2:0] MODE_LINEAR = 3'b001;
  localparam logic [2:0] MODE_OFF    = 3'b010;
  localparam logic [2:0] MODE_ON     = 3'b011;
  localparam logic [2:0] MODE_PEAK   = 3'b100;
  localparam logic [2:0] MODE_DOT    = 3'b101;

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_IDLE  = 2'd1,
    S_APPLY = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                ready_q, ready_d;
  logic                err_q, err_d;
  logic [2:0]          com_q, com_d;
  logic [VALSIZE-1:0]  min_q, min_d;
  logic [VALSIZE-1:0]  max_q, max_d;
  logic [VALSIZE-1:0]  value_q, value_d;
  logic [VALSIZE-1:0]  peak_q, peak_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                phase_q, phase_d;
  logic [NLED-1:0]     leds_q, leds_d;

  logic accept;
  logic cfg_ok;
  logic take;

  assign accept = cfg_valid_i & ready_q;
  assign cfg_ok = (cfg_min_i <= cfg_max_i);
  assign take   = accept & cfg_ok;

  // Next-state for FSM, configuration, value/peak and blink generator
  always_comb begin
    state_d = state_q;
    com_d   = com_q;
    min_d   = min_q;
    max_d   = max_q;
    value_d = value_q;
    peak_d  = peak_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;

    case (state_q)
      S_INIT:  state_d = S_IDLE;
      S_IDLE:  if (take) state_d = S_APPLY;
      S_APPLY: state_d = S_IDLE;
      default: state_d = S_INIT;
    endcase

    ready_d = (state_d == S_IDLE);
    err_d   = accept & ~cfg_ok;

    if (val_valid_i) value_d = val_i;

    if (take) begin
      com_d   = cfg_com_i;
      min_d   = cfg_min_i;
      max_d   = cfg_max_i;
      // Peak restarts from the new lower bound, then sees a same-cycle value
      peak_d  = cfg_min_i;
      if (val_valid_i && (val_i > cfg_min_i)) peak_d = val_i;
      cnt_d   = '0;
      phase_d = 1'b1;
    end else begin
      if (val_valid_i && (com_q == MODE_PEAK) && (val_i > peak_q)) peak_d = val_i;
      if (cnt_q == CW'(BLINK_DIV - 1)) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d   = cnt_q + CW'(1);
      end
    end
  end

  // LED pattern from post-edge register values; indices held in IW bits
  always_comb begin
    logic [IW-1:0] lo, hi, v, pk, ix;
    logic          in_rng, pk_ok;
    leds_d = '0;
    lo     = {1'b0, min_d};
    hi     = {1'b0, max_d};
    v      = {1'b0, value_d};
    pk     = {1'b0, peak_d};
    ix     = '0;
    in_rng = (lo <= v) && (v <= hi);
    pk_ok  = (lo <= pk) && (pk <= hi);
    for (int i = 0; i < NLED; i++) begin
      ix = IW'(i);
      case (com_d)
        MODE_NORMAL: leds_d[i] = in_rng &&
                                 (((ix >= lo) && (ix <= v)) ||
                                  ((ix > v) && (ix <= hi) && phase_d));
        MODE_LINEAR: leds_d[i] = (ix <= v);
        MODE_OFF:    leds_d[i] = 1'b0;
        MODE_ON:     leds_d[i] = 1'b1;
        MODE_PEAK:   leds_d[i] = ((v >= lo) && (ix >= lo) && (ix <= v)) ||
                                 (pk_ok && (ix == pk));
        MODE_DOT:    leds_d[i] = (ix == v);
        default:     leds_d[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_INIT;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      com_q   <= MODE_OFF;
      min_q   <= '0;
      max_q   <= '1;
      value_q <= '0;
      peak_q  <= '0;
      cnt_q   <= '0;
      phase_q <= 1'b1;
      leds_q  <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      com_q   <= com_d;
      min_q   <= min_d;
      max_q   <= max_d;
      value_q <= value_d;
      peak_q  <= peak_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      leds_q  <= leds_d;
    end
  end

  assign cfg_ready_o = ready_q;
  assign cfg_err_o   = err_q;
  assign leds_o      = leds_q;

endmodule

// File: tb/tb_min_max_seq.sv
// Directed self-checking bench for min_max_seq (VALSIZE=4, BLINK_DIV=4).
module tb_min_max_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [2:0]  cfg_com;
  logic [3:0]  cfg_min;
  logic [3:0]  cfg_max;
  logic        cfg_err;
  logic        val_valid;
  logic [3:0]  val;
  logic [15:0] leds;

  int errors = 0;
  int checks = 0;

  min_max_seq #(.VALSIZE(4), .BLINK_DIV(4)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .cfg_valid_i (cfg_valid),
    .cfg_ready_o (cfg_ready),
    .cfg_com_i   (cfg_com),
    .cfg_min_i   (cfg_min),
    .cfg_max_i   (cfg_max),
    .cfg_err_o   (cfg_err),
    .val_valid_i (val_valid),
    .val_i       (val),
    .leds_o      (leds)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds cfg_valid until a handshake edge; returns just after that edge
  task automatic send_cfg(input logic [2:0] com, input logic [3:0] mn, input logic [3:0] mx);
    logic was_ready;
    bit   done;
    done      = 1'b0;
    cfg_valid = 1'b1;
    cfg_com   = com;
    cfg_min   = mn;
    cfg_max   = mx;
    for (int n = 0; n < 10 && !done; n++) begin
      was_ready = cfg_ready;
      tick();
      if (was_ready) done = 1'b1;
    end
    cfg_valid = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL cfg_handshake ready never seen, done=%0d exp=1", done);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_com = '0; cfg_min = '0; cfg_max = '0;
    val_valid = 1'b0; val = '0;
    #3;
    checks++; if (leds !== 16'h0000) begin errors++; $display("FAIL rst_leds got=%h exp=%h", leds, 16'h0000); end
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got=%b exp=0", cfg_ready); end
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL rst_err got=%b exp=0", cfg_err); end
    #20;
    rst_n = 1'b1;
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL init_ready got=%b exp=0", cfg_ready); end
    tick();
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL idle_ready got=%b exp=1", cfg_ready); end
    checks++; if (leds !== 16'h0000) begin errors++; $display("FAIL idle_leds got=%h exp=%h", leds, 16'h0000); end
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL idle_err got=%b exp=0", cfg_err); end
  endtask

  task automatic test_normal_blink();
    send_cfg(3'b000, 4'd3, 4'd12);
    checks++; if (leds !== 16'h0000) begin errors++; $display("FAIL norm_oor got=%h exp=%h", leds, 16'h0000); end
    val_valid = 1'b1; val = 4'd8;
    tick();
    val_valid = 1'b0;
    checks++; if (leds !== 16'h1FF8) begin errors++; $display("FAIL norm_e1 got=%h exp=%h", leds, 16'h1FF8); end
    tick(); tick();
    checks++; if (leds !== 16'h1FF8) begin errors++; $display("FAIL norm_e3 got=%h exp=%h", leds, 16'h1FF8); end
    tick();
    checks++; if (leds !== 16'h01F8) begin errors++; $display("FAIL norm_e4 got=%h exp=%h", leds, 16'h01F8); end
    tick(); tick(); tick();
    checks++; if (leds !== 16'h01F8) begin errors++; $display("FAIL norm_e7 got=%h exp=%h", leds, 16'h01F8); end
    tick();
    checks++; if (leds !== 16'h1FF8) begin errors++; $display("FAIL norm_e8 got=%h exp=%h", leds, 16'h1FF8); end
  endtask

  task automatic test_cfg_error();
    send_cfg(3'b000, 4'd10, 4'd5);
    checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL err_pulse got=%b exp=1", cfg_err); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL err_ready got=%b exp=1", cfg_ready); end
    checks++; if ((leds & 16'hE1FF) !== 16'h01F8) begin errors++; $display("FAIL err_keep got=%h exp=%h", leds & 16'hE1FF, 16'h01F8); end
    tick();
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL err_one_cycle got=%b exp=0", cfg_err); end
    checks++; if ((leds & 16'hE1FF) !== 16'h01F8) begin errors++; $display("FAIL err_keep2 got=%h exp=%h", leds & 16'hE1FF, 16'h01F8); end
  endtask

  task automatic test_peak();
    logic [3:0]  vals [3];
    logic [15:0] exps [3];
    vals = '{4'd7, 4'd11, 4'd4};
    exps = '{16'h00FC, 16'h0FFC, 16'h081C};
    send_cfg(3'b100, 4'd2, 4'd14);
    checks++; if (leds !== 16'h01FC) begin errors++; $display("FAIL peak_cfg got=%h exp=%h", leds, 16'h01FC); end
    for (int k = 0; k < 3; k++) begin
      val_valid = 1'b1; val = vals[k];
      tick();
      val_valid = 1'b0;
      checks++; if (leds !== exps[k]) begin errors++; $display("FAIL peak_v%0d got=%h exp=%h", k, leds, exps[k]); end
    end
    send_cfg(3'b100, 4'd2, 4'd14);
    checks++; if (leds !== 16'h001C) begin errors++; $display("FAIL peak_clear got=%h exp=%h", leds, 16'h001C); end
  endtask

  task automatic test_cfg_with_value();
    tick();
    val_valid = 1'b1; val = 4'd5;
    send_cfg(3'b100, 4'd6, 4'd14);
    val_valid = 1'b0;
    checks++; if (leds !== 16'h0040) begin errors++; $display("FAIL same_cycle got=%h exp=%h", leds, 16'h0040); end
  endtask

  task automatic test_back_to_back();
    tick();
    cfg_valid = 1'b1; cfg_com = 3'b101; cfg_min = 4'd0; cfg_max = 4'd15;
    tick();
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL b2b_apply_ready got=%b exp=0", cfg_ready); end
    checks++; if (leds !== 16'h0020) begin errors++; $display("FAIL b2b_first got=%h exp=%h", leds, 16'h0020); end
    cfg_com = 3'b001;
    tick();
    checks++; if (leds !== 16'h0020) begin errors++; $display("FAIL b2b_ignored got=%h exp=%h", leds, 16'h0020); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_back got=%b exp=1", cfg_ready); end
    tick();
    cfg_valid = 1'b0;
    checks++; if (leds !== 16'h003F) begin errors++; $display("FAIL b2b_second got=%h exp=%h", leds, 16'h003F); end
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL b2b_apply2 got=%b exp=0", cfg_ready); end
  endtask

  task automatic test_boundaries();
    logic [2:0]  coms [7];
    logic [3:0]  mns  [7];
    logic [3:0]  mxs  [7];
    logic [3:0]  vs   [7];
    logic [15:0] exps [7];
    coms = '{3'b000, 3'b000, 3'b001, 3'b011, 3'b110, 3'b101, 3'b000};
    mns  = '{4'd0,   4'd7,   4'd0,   4'd0,   4'd0,   4'd0,   4'd3};
    mxs  = '{4'd15,  4'd7,   4'd15,  4'd15,  4'd15,  4'd15,  4'd12};
    vs   = '{4'd15,  4'd7,   4'd15,  4'd1,   4'd9,   4'd15,  4'd13};
    exps = '{16'hFFFF, 16'h0080, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h8000, 16'h0000};
    for (int k = 0; k < 7; k++) begin
      val_valid = 1'b1; val = vs[k];
      send_cfg(coms[k], mns[k], mxs[k]);
      val_valid = 1'b0;
      checks++; if (leds !== exps[k]) begin errors++; $display("FAIL bound_%0d got=%h exp=%h", k, leds, exps[k]); end
      if (k == 0) begin
        tick(); tick(); tick(); tick(); tick();
        checks++; if (leds !== 16'hFFFF) begin errors++; $display("FAIL bound_noblink got=%h exp=%h", leds, 16'hFFFF); end
      end
    end
  endtask

  task automatic test_async_reset();
    tick();
    val_valid = 1'b1; val = 4'd8;
    send_cfg(3'b000, 4'd3, 4'd12);
    val_valid = 1'b0;
    tick(); tick(); tick(); tick(); tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (leds !== 16'h0000) begin errors++; $display("FAIL arst_leds got=%h exp=%h", leds, 16'h0000); end
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL arst_ready got=%b exp=0", cfg_ready); end
    #3;
    rst_n = 1'b1;
    tick();
    val_valid = 1'b1; val = 4'd8;
    send_cfg(3'b000, 4'd3, 4'd12);
    val_valid = 1'b0;
    checks++; if (leds !== 16'h1FF8) begin errors++; $display("FAIL arst_phase1 got=%h exp=%h", leds, 16'h1FF8); end
    tick(); tick(); tick();
    checks++; if (leds !== 16'h1FF8) begin errors++; $display("FAIL arst_e3 got=%h exp=%h", leds, 16'h1FF8); end
    tick();
    checks++; if (leds !== 16'h01F8) begin errors++; $display("FAIL arst_e4 got=%h exp=%h", leds, 16'h01F8); end
  endtask

  initial begin
    test_reset();
    test_normal_blink();
    test_cfg_error();
    test_peak();
    test_cfg_with_value();
    test_back_to_back();
    test_boundaries();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
